mips_alu_mc: RTL and testbench

Multicycle ALU that consumes the 3-bit `ALUControl` code from the ALU decoder and the two 32-bit operands from the register-file/immediate mux. It produces a registered `ALUResult`/`Zero` pair. Single-cycle operations (AND, OR, ADD, SUB, SLT) complete in one clock. `mul` (low 32 bits of the product) runs as a 32-iteration shift-add sequence behind a `Start`/`Busy`/`Valid` handshake, so the pipeline stalls only while a multiply is in flight.

---
 rtl/mips_pkg.sv | 22 ++
 rtl/alu_mul_seq.sv | 52 +++++
 rtl/mips_alu_mc.sv | 109 ++++++++++
 tb/tb_mips_alu_mc.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared ALU control codes and multicycle-ALU FSM encoding.
// The ALU decoder imports these same constants so both sides agree on the codes.
package mips_pkg;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b100;
  localparam logic [2:0] ALU_MUL = 3'b101;
  localparam logic [2:0] ALU_SLT = 3'b110;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } alu_state_e;

  // Only the multiply leaves IDLE; every other code completes in one clock.
  function automatic logic is_multicycle(input logic [2:0] code);
    return code == ALU_MUL;
  endfunction

endpackage

// File: rtl/alu_mul_seq.sv
// Shift-add multiplier datapath: one partial product per step, WIDTH steps total.
// Keeps only the low WIDTH bits, which match for signed and unsigned operands.
module alu_mul_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             step,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] product,
  output logic             last
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [WIDTH-1:0] multiplicand;
  logic [WIDTH-1:0] multiplier;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_next;
  logic [CW-1:0]    cnt;

  assign acc_next = acc + (multiplier[0] ? multiplicand : '0);

  // The product leaves through acc_next so the final step is captured on the
  // same edge that performs it, without an extra drain cycle.
  assign product = acc_next;
  assign last    = (cnt == CW'(WIDTH - 1));

  // NOTE: every register here is reset, not just control state; an aborted
  // multiply must leave no partial operands behind for the next one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      multiplicand <= '0;
      multiplier   <= '0;
      acc          <= '0;
      cnt          <= '0;
    end else if (load) begin
      multiplicand <= a;
      multiplier   <= b;
      acc          <= '0;
      cnt          <= '0;
    end else if (step) begin
      acc          <= acc_next;
      multiplicand <= multiplicand << 1;
      multiplier   <= multiplier >> 1;
      cnt          <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/mips_alu_mc.sv
// Multicycle MIPS ALU: single-cycle logic/arith ops plus a WIDTH-step multiply
// behind a Start/Busy/Valid handshake. All result outputs are registered.
module mips_alu_mc
  import mips_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  input  logic [2:0]       ALUControl,
  input  logic             Start,
  output logic [WIDTH-1:0] ALUResult,
  output logic             Zero,
  output logic             Busy,
  output logic             Valid
);

  alu_state_e       state;
  alu_state_e       state_next;
  logic             mul_load;
  logic             mul_step;
  logic             mul_last;
  logic [WIDTH-1:0] mul_product;
  logic             done;
  logic [WIDTH-1:0] alu_y;
  logic [WIDTH-1:0] res_next;

  alu_mul_seq #(
    .WIDTH(WIDTH)
  ) u_mul (
    .clk    (CLK),
    .rst_n  (RST),
    .load   (mul_load),
    .step   (mul_step),
    .a      (SrcA),
    .b      (SrcB),
    .product(mul_product),
    .last   (mul_last)
  );

  // NOTE: state uses <= so every register samples pre-edge values together;
  // = here would let later blocks see the updated state within the same edge.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state <= ST_IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE: if (Start && is_multicycle(ALUControl)) state_next = ST_MUL;
      ST_MUL:  if (mul_last)                           state_next = ST_IDLE;
      default:                                         state_next = ST_IDLE;
    endcase
  end

  // NOTE: defaults first so that no path through the case leaves an output
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    mul_load = 1'b0;
    mul_step = 1'b0;
    done     = 1'b0;
    Busy     = 1'b0;
    unique case (state)
      ST_IDLE: begin
        mul_load = Start && is_multicycle(ALUControl);
        done     = Start && !is_multicycle(ALUControl);
      end
      ST_MUL: begin
        Busy     = 1'b1;
        mul_step = 1'b1;
        done     = mul_last;
      end
      default: ;
    endcase
  end

  // Single-cycle datapath; reserved codes deliberately produce zero.
  always_comb begin
    alu_y = '0;
    unique case (ALUControl)
      ALU_AND: alu_y = SrcA & SrcB;
      ALU_OR:  alu_y = SrcA | SrcB;
      ALU_ADD: alu_y = SrcA + SrcB;
      ALU_SUB: alu_y = SrcA - SrcB;
      ALU_SLT: alu_y = {{(WIDTH-1){1'b0}}, ($signed(SrcA) < $signed(SrcB))};
      default: alu_y = '0;
    endcase
  end

  assign res_next = (state == ST_MUL) ? mul_product : alu_y;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      ALUResult <= '0;
      Zero      <= 1'b1;
      Valid     <= 1'b0;
    end else begin
      Valid <= done;
      if (done) begin
        ALUResult <= res_next;
        Zero      <= (res_next == '0);
      end
    end
  end

endmodule

// File: tb/tb_mips_alu_mc.sv
// Scoreboard bench for mips_alu_mc: expected results are queued at issue time
// and popped when Valid appears; Busy duration and Valid pulse width are checked.
module tb_mips_alu_mc;
  import mips_pkg::*;

  typedef struct {
    logic [31:0] res;
    logic        zero;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic [31:0] srca;
  logic [31:0] srcb;
  logic [2:0]  ctl;
  logic        start;
  logic [31:0] alu_result;
  logic        zero;
  logic        busy;
  logic        valid;

  exp_t exp_q[$];
  int   checks;
  int   errors;

  mips_alu_mc #(.WIDTH(32)) dut (
    .CLK       (clk),
    .RST       (rst_n),
    .SrcA      (srca),
    .SrcB      (srcb),
    .ALUControl(ctl),
    .Start     (start),
    .ALUResult (alu_result),
    .Zero      (zero),
    .Busy      (busy),
    .Valid     (valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    case (c)
      3'b000:  e.res = a & b;
      3'b001:  e.res = a | b;
      3'b010:  e.res = a + b;
      3'b100:  e.res = a - b;
      3'b101:  e.res = a * b;
      3'b110:  e.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: e.res = 32'd0;
    endcase
    e.zero = (e.res == 32'd0);
    return e;
  endfunction

  // Drive one request at a falling edge; unless held, Start drops right after the accepting edge.
  task automatic issue(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b, input bit hold);
    @(negedge clk);
    start = 1'b1;
    ctl   = c;
    srca  = a;
    srcb  = b;
    exp_q.push_back(model(c, a, b));
    @(posedge clk);
    #1;
    if (!hold) start = 1'b0;
  endtask

  task automatic compare_pop(input string tag);
    exp_t e;
    if (exp_q.size() == 0) begin
      check({tag, "_unexpected_valid"}, 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      check({tag, "_result"}, alu_result, e.res);
      check({tag, "_zero"}, {31'd0, zero}, {31'd0, e.zero});
    end
  endtask

  // Wait (bounded) for Valid, counting Busy cycles on the way.
  task automatic collect(input string tag, input int exp_busy);
    int busy_n;
    bit got;
    busy_n = 0;
    got    = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (busy && valid) check({tag, "_busy_valid_overlap"}, 32'd1, 32'd0);
      if (valid) begin
        got = 1'b1;
        break;
      end
      if (busy) busy_n++;
    end
    if (!got) check({tag, "_timeout"}, 32'd0, 32'd1);
    else      compare_pop(tag);
    check({tag, "_busy_cycles"}, busy_n, exp_busy);
  endtask

  task automatic pulse_end(input string tag);
    @(negedge clk);
    check({tag, "_valid_pulse_width"}, {31'd0, valid}, 32'd0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    start  = 1'b0;
    ctl    = 3'b000;
    srca   = '0;
    srcb   = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_result", alu_result, 32'd0);
    check("reset_zero", {31'd0, zero}, 32'd1);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_valid", {31'd0, valid}, 32'd0);

    issue(ALU_ADD, 32'd5, 32'd7, 1'b0);               collect("add_5_7", 0);     pulse_end("add_5_7");
    issue(ALU_SUB, 32'd3, 32'd3, 1'b0);               collect("sub_3_3", 0);     pulse_end("sub_3_3");
    issue(ALU_SLT, 32'hFFFF_FFFF, 32'd1, 1'b0);       collect("slt_neg_pos", 0); pulse_end("slt_neg_pos");
    issue(ALU_SLT, 32'd1, 32'hFFFF_FFFF, 1'b0);       collect("slt_pos_neg", 0); pulse_end("slt_pos_neg");
    issue(ALU_AND, 32'hF0F0_1234, 32'h0FF0_FF00, 1'b0); collect("and", 0);       pulse_end("and");
    issue(ALU_OR,  32'hF0F0_0000, 32'h000F_00FF, 1'b0); collect("or", 0);        pulse_end("or");
    issue(ALU_ADD, 32'hFFFF_FFFF, 32'd2, 1'b0);       collect("add_wrap", 0);    pulse_end("add_wrap");
    issue(3'b111, 32'd9, 32'd9, 1'b0);                collect("reserved_111", 0); pulse_end("reserved_111");
    issue(3'b011, 32'd9, 32'd9, 1'b0);                collect("reserved_011", 0); pulse_end("reserved_011");

    issue(ALU_MUL, 32'd12345, 32'd6789, 1'b0);        collect("mul_12345_6789", 32); pulse_end("mul_12345_6789");
    issue(ALU_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0); collect("mul_all_ones", 32); pulse_end("mul_all_ones");
    issue(ALU_MUL, 32'd0, 32'd7, 1'b0);               collect("mul_zero", 32);   pulse_end("mul_zero");
    issue(ALU_MUL, 32'd7, 32'd0, 1'b0);               collect("mul_by_zero", 32); pulse_end("mul_by_zero");

    // ADD held on Start for the whole multiply: ignored while Busy, accepted in the Valid cycle.
    issue(ALU_MUL, 32'd100, 32'd200, 1'b1);
    ctl  = ALU_ADD;
    srca = 32'd1;
    srcb = 32'd2;
    exp_q.push_back(model(ALU_ADD, 32'd1, 32'd2));
    collect("mul_held_start", 32);
    @(negedge clk);
    check("b2b_add_valid", {31'd0, valid}, 32'd1);
    check("b2b_add_busy", {31'd0, busy}, 32'd0);
    if (valid) compare_pop("b2b_add");
    start = 1'b0;
    pulse_end("b2b_add");

    // Reset roughly ten iterations into a multiply abandons it outright.
    issue(ALU_MUL, 32'd7, 32'd9, 1'b0);
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_valid", {31'd0, valid}, 32'd0);
    check("abort_result", alu_result, 32'd0);
    check("abort_zero", {31'd0, zero}, 32'd1);
    exp_q.delete(exp_q.size() - 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (40) begin
      @(negedge clk);
      if (valid) check("abort_stale_valid", 32'd1, 32'd0);
    end
    check("abort_idle_busy", {31'd0, busy}, 32'd0);
    issue(ALU_MUL, 32'd3, 32'd4, 1'b0);               collect("mul_after_reset", 32); pulse_end("mul_after_reset");

    check("scoreboard_empty", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
